// File: rtl/adau1761_regs_pkg.sv
// Shared constants and state encodings for the ADAU1761 AXI4-Lite register block.
package adau1761_regs_pkg;

  // Register file geometry: four 32-bit words, word index taken from ADDR[3:2].
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  // Byte offsets of the mapped registers.
  localparam int REG0_OFFSET = 'h00;
  localparam int REG1_OFFSET = 'h04;
  localparam int REG2_OFFSET = 'h08;
  localparam int REG3_OFFSET = 'h0C;

  // AXI response codes used by this block.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write channel FSM: collects AW and W in either order, then answers on B.
  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  // Read channel FSM: one outstanding read at a time.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/adau1761_axil_regs_if.sv
// AXI4-Lite bus bundle for the ADAU1761 control registers.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where VALID and READY are both 1. A source holds VALID and its payload stable
// until that edge; READY may be asserted independently of VALID.
interface adau1761_axil_regs_if #(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_DATA_WIDTH = 32
);

  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                AWPROT;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      WVALID;
  logic                      WREADY;

  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                ARPROT;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/adau1761_reg_bank.sv
// Register storage with address decode and byte-strobe merge.
// One write port (applied on the clock edge when wr_en is high) and one
// combinational read port; reads see the pre-write contents during a write cycle.
module adau1761_reg_bank
  import adau1761_regs_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic [DATA_W/8-1:0]              wr_strb,
  output logic                             wr_mapped,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_mapped,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  regs_out
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [REG_IDX_W-1:0]            wr_idx;
  logic [REG_IDX_W-1:0]            rd_idx;
  logic                            unused_addr_bits;

  // Byte offset bits select nothing; anything above bit 3 means unmapped.
  assign wr_idx    = wr_addr[3:2];
  assign rd_idx    = rd_addr[3:2];
  assign wr_mapped = (wr_addr[ADDR_W-1:4] == '0);
  assign rd_mapped = (rd_addr[ADDR_W-1:4] == '0);
  assign unused_addr_bits = &{1'b0, wr_addr[1:0], rd_addr[1:0]};

  // Byte-lane merge into the addressed register; unmapped writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_en && wr_mapped) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data  = rd_mapped ? regs[rd_idx] : '0;
  assign regs_out = regs;

endmodule

// File: rtl/adau1761_axil_regs.sv
// AXI4-Lite slave exposing four read/write control registers for the ADAU1761
// codec. Independent write and read FSMs, each with one transaction in flight.
module adau1761_axil_regs
  import adau1761_regs_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  adau1761_axil_regs_if.slave                   s_axi,
  output logic [NUM_REGS-1:0][C_DATA_WIDTH-1:0] REG_OUT,
  output w_state_t                              w_state_dbg,
  output r_state_t                              r_state_dbg
);

  w_state_t                  w_state;
  r_state_t                  r_state;
  logic [C_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_DATA_WIDTH-1:0]   w_data_q;
  logic [C_DATA_WIDTH/8-1:0] w_strb_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      have_aw;
  logic                      have_w;
  logic                      wr_en;
  logic                      wr_mapped;
  logic                      rd_mapped;
  logic [C_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_DATA_WIDTH-1:0]   wr_data;
  logic [C_DATA_WIDTH/8-1:0] wr_strb;
  logic [C_DATA_WIDTH-1:0]   rd_data;
  logic                      unused_prot;

  assign unused_prot = &{1'b0, s_axi.AWPROT, s_axi.ARPROT};

  assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
  assign w_hs  = s_axi.WVALID  && s_axi.WREADY;
  assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;

  // Address/data are "held" once either arriving now or latched earlier; the
  // register update fires on the edge where both are available.
  assign have_aw = aw_hs || (w_state == W_HAVE_AW);
  assign have_w  = w_hs  || (w_state == W_HAVE_W);
  assign wr_en   = have_aw && have_w;
  assign wr_addr = (w_state == W_HAVE_AW) ? aw_addr_q : s_axi.AWADDR;
  assign wr_data = (w_state == W_HAVE_W)  ? w_data_q  : s_axi.WDATA;
  assign wr_strb = (w_state == W_HAVE_W)  ? w_strb_q  : s_axi.WSTRB;

  adau1761_reg_bank #(
    .ADDR_W (C_ADDR_WIDTH),
    .DATA_W (C_DATA_WIDTH)
  ) u_bank (
    .clk       (ACLK),
    .rst       (ARESET),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_mapped (wr_mapped),
    .rd_addr   (s_axi.ARADDR),
    .rd_data   (rd_data),
    .rd_mapped (rd_mapped),
    .regs_out  (REG_OUT)
  );

  // Write FSM: gather AW and W in any order, then hold B until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      s_axi.AWREADY <= 1'b0;
      s_axi.WREADY  <= 1'b0;
      s_axi.BVALID  <= 1'b0;
      s_axi.BRESP   <= RESP_OKAY;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_axi.AWADDR;
      if (w_hs) begin
        w_data_q <= s_axi.WDATA;
        w_strb_q <= s_axi.WSTRB;
      end
      case (w_state)
        W_IDLE, W_HAVE_AW, W_HAVE_W: begin
          if (wr_en) begin
            w_state       <= W_RESP;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b0;
            s_axi.BVALID  <= 1'b1;
            s_axi.BRESP   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
          end else if (have_aw) begin
            w_state       <= W_HAVE_AW;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b1;
          end else if (have_w) begin
            w_state       <= W_HAVE_W;
            s_axi.AWREADY <= 1'b1;
            s_axi.WREADY  <= 1'b0;
          end else begin
            w_state       <= W_IDLE;
            s_axi.AWREADY <= 1'b1;
            s_axi.WREADY  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.BVALID && s_axi.BREADY) begin
            w_state       <= W_IDLE;
            s_axi.BVALID  <= 1'b0;
            s_axi.AWREADY <= 1'b1;
            s_axi.WREADY  <= 1'b1;
          end
        end
        default: begin
          w_state       <= W_IDLE;
          s_axi.BVALID  <= 1'b0;
          s_axi.AWREADY <= 1'b0;
          s_axi.WREADY  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: capture data on the AR edge and hold it until R is accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      s_axi.ARREADY <= 1'b0;
      s_axi.RVALID  <= 1'b0;
      s_axi.RDATA   <= '0;
      s_axi.RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            s_axi.ARREADY <= 1'b0;
            s_axi.RVALID  <= 1'b1;
            s_axi.RDATA   <= rd_data;
            s_axi.RRESP   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
          end else begin
            s_axi.ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.RVALID && s_axi.RREADY) begin
            r_state       <= R_IDLE;
            s_axi.RVALID  <= 1'b0;
            s_axi.ARREADY <= 1'b1;
          end
        end
        default: begin
          r_state       <= R_IDLE;
          s_axi.RVALID  <= 1'b0;
          s_axi.ARREADY <= 1'b0;
        end
      endcase
    end
  end

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

endmodule

// File: tb/tb_adau1761_axil_regs.sv
// Directed bench for adau1761_axil_regs: write/read sequences with a small
// register model and response queues.
module tb_adau1761_axil_regs;
  import adau1761_regs_pkg::*;

  // ---------------- clock / reset ----------------
  logic ACLK;
  logic ARESET;
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  adau1761_axil_regs_if #(.C_ADDR_WIDTH(6), .C_DATA_WIDTH(32)) bus ();

  logic [NUM_REGS-1:0][31:0] reg_out;
  w_state_t                  w_dbg;
  r_state_t                  r_dbg;

  adau1761_axil_regs #(.C_ADDR_WIDTH(6), .C_DATA_WIDTH(32)) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_axi       (bus.slave),
    .REG_OUT     (reg_out),
    .w_state_dbg (w_dbg),
    .r_state_dbg (r_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] model [NUM_REGS];
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_mapped(input logic [5:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s_reg%0d", tag, i), 34'(reg_out[i]), 34'(model[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_hold);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin
        bus.AWADDR = addr; bus.AWPROT = 3'($urandom_range(0, 7)); bus.AWVALID = 1'b1;
      end
      if (!w_done && cyc >= w_dly) begin
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
      end
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      step();
      cyc++;
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.WVALID = 1'b0; end
      if (!(aw_done && w_done)) begin
        check("bvalid_early", 34'(bus.BVALID), 34'd0);
        if (aw_done) check("w_state_have_aw", 34'(w_dbg), 34'(W_HAVE_AW));
        if (w_done)  check("w_state_have_w", 34'(w_dbg), 34'(W_HAVE_W));
      end
    end
    check("wr_accepted", 34'({aw_done, w_done}), 34'd3);
    if (!(aw_done && w_done)) begin
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      return;
    end
    check("bvalid_latency", 34'(bus.BVALID), 34'd1);
    if (is_mapped(addr)) begin
      model[addr[3:2]] = merge(model[addr[3:2]], data, strb);
      exp_resp = RESP_OKAY;
    end else begin
      exp_resp = RESP_SLVERR;
    end
    exp_b_q.push_back(exp_resp);
    check_regs("wr_update");
    repeat (b_hold) begin
      check("b_hold_valid", 34'(bus.BVALID), 34'd1);
      check("b_hold_resp", 34'(bus.BRESP), 34'(exp_b_q[0]));
      check("b_hold_no_accept", 34'({bus.AWREADY, bus.WREADY}), 34'd0);
      step();
    end
    bus.BREADY = 1'b1;
    check("bresp", 34'(bus.BRESP), 34'(exp_b_q.pop_front()));
    step();
    bus.BREADY = 1'b0;
    check("b_done", 34'({bus.BVALID, bus.AWREADY, bus.WREADY}), 34'b011);
  endtask

  task automatic read_issue(input logic [5:0] addr);
    bit done, hs;
    int cyc;
    done = 0; cyc = 0;
    bus.ARADDR = addr; bus.ARPROT = 3'($urandom_range(0, 7)); bus.ARVALID = 1'b1;
    while (!done && cyc < 20) begin
      hs = bus.ARVALID && bus.ARREADY;
      step();
      cyc++;
      if (hs) done = 1;
    end
    bus.ARVALID = 1'b0;
    check("ar_accepted", 34'(done), 34'd1);
    if (is_mapped(addr)) exp_r_q.push_back({RESP_OKAY, model[addr[3:2]]});
    else                 exp_r_q.push_back({RESP_SLVERR, 32'h0});
    check("rvalid_latency", 34'(bus.RVALID), 34'd1);
  endtask

  task automatic read_finish(input int r_hold);
    repeat (r_hold) begin
      check("r_hold_valid", 34'(bus.RVALID), 34'd1);
      check("r_hold_data", {bus.RRESP, bus.RDATA}, exp_r_q[0]);
      check("r_hold_no_accept", 34'(bus.ARREADY), 34'd0);
      step();
    end
    bus.RREADY = 1'b1;
    check("rdata_rresp", {bus.RRESP, bus.RDATA}, exp_r_q.pop_front());
    step();
    bus.RREADY = 1'b0;
    check("r_done", 34'({bus.RVALID, bus.ARREADY}), 34'b01);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    ARESET = 1'b1;

    // Reset values
    step();
    check("rst_bvalid", 34'(bus.BVALID), 34'd0);
    check("rst_rvalid", 34'(bus.RVALID), 34'd0);
    check("rst_resps", 34'({bus.BRESP, bus.RRESP}), 34'd0);
    check("rst_rdata", 34'(bus.RDATA), 34'd0);
    check_regs("rst");
    ARESET = 1'b0;
    step();
    check("post_rst_ready", 34'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 34'b111);

    // Basic write then read-back of all four registers
    for (int i = 0; i < NUM_REGS; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) begin read_issue(6'(i * 4)); read_finish(0); end

    // W three cycles ahead of AW
    do_write(6'(REG2_OFFSET), 32'hA5A5_0033, 4'hF, 3, 0, 0);
    // AW two cycles ahead of W, offset bits set (ignored)
    do_write(6'(REG3_OFFSET + 3), 32'h0BAD_F00D, 4'hF, 0, 2, 0);
    read_issue(6'(REG3_OFFSET)); read_finish(0);

    // Byte strobes
    do_write(6'(REG0_OFFSET), 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(6'(REG0_OFFSET), 32'h1234_5678, 4'b0101, 0, 0, 0);
    read_issue(6'(REG0_OFFSET)); read_finish(0);
    check("strobe_merge", 34'(reg_out[0]), 34'h0FF34FF78);
    do_write(6'(REG1_OFFSET), 32'hDEAD_DEAD, 4'h0, 0, 0, 0);

    // Unmapped accesses
    do_write(6'h10, 32'hCAFE_CAFE, 4'hF, 0, 0, 0);
    read_issue(6'h20); read_finish(0);
    check_regs("unmapped");

    // Back-pressure on B and R; write lands in the register under a stalled read
    do_write(6'(REG1_OFFSET), 32'h5555_AAAA, 4'hF, 0, 0, 5);
    read_issue(6'(REG1_OFFSET));
    do_write(6'(REG1_OFFSET), 32'h0123_4567, 4'hF, 0, 0, 0);
    read_finish(5);
    read_issue(6'(REG1_OFFSET)); read_finish(0);

    // Randomised accesses across the whole address space
    for (int n = 0; n < 8; n++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 15) * 4);
      do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2));
      read_issue(a);
      read_finish($urandom_range(0, 2));
    end

    // Reset while the write FSM holds only an address
    bus.AWADDR = 6'(REG1_OFFSET); bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    check("pre_rst_have_aw", 34'(w_dbg), 34'(W_HAVE_AW));
    #2 ARESET = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    exp_b_q.delete();
    exp_r_q.delete();
    check("mid_rst_state", 34'(w_dbg), 34'(W_IDLE));
    check("mid_rst_bvalid", 34'(bus.BVALID), 34'd0);
    check_regs("mid_rst");
    step();
    ARESET = 1'b0;
    step();
    check("after_rst_bvalid", 34'(bus.BVALID), 34'd0);
    check("after_rst_ready", 34'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 34'b111);
    check("after_rst_reg1", 34'(reg_out[1]), 34'd0);
    do_write(6'(REG1_OFFSET), 32'h7777_1111, 4'hF, 0, 0, 0);
    read_issue(6'(REG1_OFFSET)); read_finish(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
